// File: rtl/ram_client_arbiter.sv
// rtl/ram_client_arbiter.sv - N-client arbiter for the shared main-memory port
// One grant at a time with enable/acknowledge handshake, address inversion, chaining and watchdog.
module ram_client_arbiter #(
    parameter int                       NUM_CLIENTS  = 4,
    parameter int                       ADDR_WIDTH   = 11,
    parameter int                       DATA_WIDTH   = 32,
    parameter int                       RR_MODE      = 0,
    parameter logic [NUM_CLIENTS-1:0]   INVERT_MASK  = '0,
    parameter logic [NUM_CLIENTS-1:0]   FOLLOW_VALID = '0,
    parameter logic [3*NUM_CLIENTS-1:0] FOLLOW_IDX   = '0,
    parameter int                       TIMEOUT      = 1024
) (
    input  logic                              CLOCK_50,
    input  logic                              resetIn,
    input  logic [NUM_CLIENTS-1:0]            req,
    output logic [NUM_CLIENTS-1:0]            enable,
    input  logic [NUM_CLIENTS-1:0]            acknowledge,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_dataWrite,
    input  logic [NUM_CLIENTS-1:0]            client_writeEnable,
    output logic [ADDR_WIDTH-1:0]             address,
    output logic [DATA_WIDTH-1:0]             dataWrite,
    output logic                              writeEnableRam,
    output logic                              busy,
    output logic [2:0]                        grant_idx,
    output logic                              timeout_err,
    output logic [2:0]                        timeout_client,
    input  logic                              clear_err
);
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t                   state;
    logic [NUM_CLIENTS-1:0]   pending;
    logic [NUM_CLIENTS-1:0]   pending_next;
    logic [NUM_CLIENTS-1:0]   cand;
    logic [2:0]               rr_ptr;
    logic [WDW-1:0]           wdog;

    logic                     win_found;
    logic [2:0]               win_idx;
    logic [NUM_CLIENTS-1:0]   win_oh;

    logic                     g_ack;
    logic [ADDR_WIDTH-1:0]    g_addr;
    logic [DATA_WIDTH-1:0]    g_data;
    logic                     g_we;
    logic                     g_fv;
    logic [2:0]               g_fi;
    logic [NUM_CLIENTS-1:0]   fol_oh;
    logic                     wd_hit;

    assign cand   = pending | req;
    assign wd_hit = (TIMEOUT != 0) && (wdog == WDW'(TIMEOUT - 1));

    // Winner search: fixed scans from index 0, round-robin scans from rr_ptr+1 with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        if (RR_MODE == 0) begin
            for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win_found = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                for (int i = 0; i < NUM_CLIENTS; i++) begin
                    if (!win_found && cand[i] && (((int'(rr_ptr) + k) % NUM_CLIENTS) == i)) begin
                        win_found = 1'b1;
                        win_idx   = 3'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        g_ack  = 1'b0;
        g_addr = '0;
        g_data = '0;
        g_we   = 1'b0;
        g_fv   = 1'b0;
        g_fi   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_idx == 3'(i)) begin
                g_ack  = acknowledge[i];
                g_addr = client_address[i*ADDR_WIDTH +: ADDR_WIDTH] ^ {ADDR_WIDTH{INVERT_MASK[i]}};
                g_data = client_dataWrite[i*DATA_WIDTH +: DATA_WIDTH];
                g_we   = client_writeEnable[i];
                g_fv   = FOLLOW_VALID[i] && (int'(FOLLOW_IDX[3*i +: 3]) < NUM_CLIENTS);
                g_fi   = FOLLOW_IDX[3*i +: 3];
            end
        end
    end

    always_comb begin
        win_oh = '0;
        fol_oh = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            win_oh[i] = (win_idx == 3'(i));
            fol_oh[i] = (g_fi == 3'(i));
        end
    end

    // An arbitrated winner consumes its request; a chained target's same-cycle req survives.
    always_comb begin
        pending_next = pending | req;
        if (state == S_IDLE && win_found)
            pending_next = pending_next & ~win_oh;
        else if (state == S_GRANT && g_ack && g_fv)
            pending_next = (pending & ~fol_oh) | req;
    end

    assign address        = busy ? g_addr : '0;
    assign dataWrite      = busy ? g_data : '0;
    assign writeEnableRam = busy ? g_we   : 1'b0;

    always_ff @(posedge CLOCK_50 or posedge resetIn) begin
        if (resetIn) begin
            state          <= S_IDLE;
            enable         <= '0;
            busy           <= 1'b0;
            grant_idx      <= '0;
            pending        <= '0;
            rr_ptr         <= 3'(NUM_CLIENTS - 1);
            timeout_err    <= 1'b0;
            timeout_client <= '0;
            wdog           <= '0;
        end else begin
            pending <= pending_next;
            if (clear_err) begin
                timeout_err    <= 1'b0;
                timeout_client <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state     <= S_GRANT;
                        busy      <= 1'b1;
                        enable    <= win_oh;
                        grant_idx <= win_idx;
                        rr_ptr    <= win_idx;
                        wdog      <= '0;
                    end
                end
                S_GRANT: begin
                    if (g_ack) begin
                        if (g_fv) begin
                            enable    <= fol_oh;
                            grant_idx <= g_fi;
                            rr_ptr    <= g_fi;
                            wdog      <= '0;
                        end else begin
                            state  <= S_IDLE;
                            busy   <= 1'b0;
                            enable <= '0;
                        end
                    end else if (wd_hit) begin
                        state          <= S_IDLE;
                        busy           <= 1'b0;
                        enable         <= '0;
                        timeout_err    <= 1'b1;
                        timeout_client <= grant_idx;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_client_arbiter.sv
// tb/tb_ram_client_arbiter.sv - self-checking bench for ram_client_arbiter
// Three configurations: fixed+invert+timeout, round-robin, fixed+chaining.
module tb_ram_client_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]   req_v [3];
    logic [3:0]   ack_v [3];
    logic [3:0]   cwe_v [3];
    logic [3:0]   en_v  [3];
    logic [43:0]  caddr_v [3];
    logic [127:0] cdata_v [3];
    logic         clr_v [3];
    logic         wer_v [3];
    logic         busy_v [3];
    logic         terr_v [3];
    logic [10:0]  addr_v [3];
    logic [31:0]  dwr_v [3];
    logic [2:0]   gidx_v [3];
    logic [2:0]   tcl_v [3];

    int checks = 0;
    int errors = 0;

    localparam int CFG_RR [3] = '{0, 1, 0};
    localparam int CFG_TO [3] = '{8, 0, 16};

    function automatic int follow_of(input int d, input int c);
        return (d == 2 && c == 1) ? 3 : -1;
    endfunction

    function automatic bit inv_of(input int d, input int c);
        return (d == 0 && c == 1) || (d == 2 && c == 3);
    endfunction

    ram_client_arbiter #(.NUM_CLIENTS(4), .ADDR_WIDTH(11), .DATA_WIDTH(32), .RR_MODE(0),
        .INVERT_MASK(4'b0010), .FOLLOW_VALID(4'b0000), .FOLLOW_IDX(12'h000), .TIMEOUT(8)) dut0 (
        .CLOCK_50(clk), .resetIn(rst), .req(req_v[0]), .enable(en_v[0]), .acknowledge(ack_v[0]),
        .client_address(caddr_v[0]), .client_dataWrite(cdata_v[0]), .client_writeEnable(cwe_v[0]),
        .address(addr_v[0]), .dataWrite(dwr_v[0]), .writeEnableRam(wer_v[0]), .busy(busy_v[0]),
        .grant_idx(gidx_v[0]), .timeout_err(terr_v[0]), .timeout_client(tcl_v[0]), .clear_err(clr_v[0]));

    ram_client_arbiter #(.NUM_CLIENTS(4), .ADDR_WIDTH(11), .DATA_WIDTH(32), .RR_MODE(1),
        .INVERT_MASK(4'b0000), .FOLLOW_VALID(4'b0000), .FOLLOW_IDX(12'h000), .TIMEOUT(0)) dut1 (
        .CLOCK_50(clk), .resetIn(rst), .req(req_v[1]), .enable(en_v[1]), .acknowledge(ack_v[1]),
        .client_address(caddr_v[1]), .client_dataWrite(cdata_v[1]), .client_writeEnable(cwe_v[1]),
        .address(addr_v[1]), .dataWrite(dwr_v[1]), .writeEnableRam(wer_v[1]), .busy(busy_v[1]),
        .grant_idx(gidx_v[1]), .timeout_err(terr_v[1]), .timeout_client(tcl_v[1]), .clear_err(clr_v[1]));

    ram_client_arbiter #(.NUM_CLIENTS(4), .ADDR_WIDTH(11), .DATA_WIDTH(32), .RR_MODE(0),
        .INVERT_MASK(4'b1000), .FOLLOW_VALID(4'b0010), .FOLLOW_IDX(12'h018), .TIMEOUT(16)) dut2 (
        .CLOCK_50(clk), .resetIn(rst), .req(req_v[2]), .enable(en_v[2]), .acknowledge(ack_v[2]),
        .client_address(caddr_v[2]), .client_dataWrite(cdata_v[2]), .client_writeEnable(cwe_v[2]),
        .address(addr_v[2]), .dataWrite(dwr_v[2]), .writeEnableRam(wer_v[2]), .busy(busy_v[2]),
        .grant_idx(gidx_v[2]), .timeout_err(terr_v[2]), .timeout_client(tcl_v[2]), .clear_err(clr_v[2]));

    // Reference model state: who holds the port, what is still waiting, watchdog age.
    bit         m_busy [3];
    bit         m_err [3];
    int         m_g [3];
    int         m_ptr [3];
    int         m_cnt [3];
    int         m_errc [3];
    logic [3:0] m_pend [3];

    task automatic zero_inputs();
        for (int d = 0; d < 3; d++) begin
            req_v[d] = '0; ack_v[d] = '0; cwe_v[d] = '0;
            caddr_v[d] = '0; cdata_v[d] = '0; clr_v[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int pick(input int d, input logic [3:0] cand);
        if (CFG_RR[d] == 0) begin
            for (int i = 0; i < 4; i++) if (cand[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (cand[(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 0; m_err[d] = 0; m_g[d] = 0; m_ptr[d] = 3;
            m_cnt[d] = 0; m_errc[d] = 0; m_pend[d] = '0;
        end
    endtask

    task automatic model_step(input int d);
        logic [3:0] cand;
        int w, f;
        bit to;
        cand = m_pend[d] | req_v[d];
        to = 0;
        if (!m_busy[d]) begin
            w = pick(d, cand);
            if (w >= 0) begin
                m_busy[d] = 1; m_g[d] = w; m_ptr[d] = w; m_cnt[d] = 0; cand[w] = 1'b0;
            end
            m_pend[d] = cand;
        end else if (ack_v[d][m_g[d]]) begin
            f = follow_of(d, m_g[d]);
            if (f >= 0) begin
                m_pend[d] = (m_pend[d] & ~(4'b0001 << f)) | req_v[d];
                m_g[d] = f; m_ptr[d] = f; m_cnt[d] = 0;
            end else begin
                m_busy[d] = 0; m_pend[d] = cand;
            end
        end else if (CFG_TO[d] != 0 && m_cnt[d] == CFG_TO[d] - 1) begin
            to = 1; m_busy[d] = 0; m_pend[d] = cand;
        end else begin
            m_cnt[d]++; m_pend[d] = cand;
        end
        if (to) begin
            m_err[d] = 1; m_errc[d] = m_g[d];
        end else if (clr_v[d]) begin
            m_err[d] = 0; m_errc[d] = 0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 4'hF; cwe_v[d] = 4'hF; caddr_v[d] = 44'hFFF_FFFF_FFFF;
            cdata_v[d] = {4{32'hDEADBEEF}}; ack_v[d] = 4'hF; clr_v[d] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++; if (en_v[d] !== 4'h0 || busy_v[d] !== 1'b0) begin errors++;
                $display("FAIL reset_grant dut%0d enable=%b busy=%b expected 0000/0", d, en_v[d], busy_v[d]); end
            checks++; if (gidx_v[d] !== 3'd0 || terr_v[d] !== 1'b0 || tcl_v[d] !== 3'd0) begin errors++;
                $display("FAIL reset_regs dut%0d gidx=%0d terr=%b tcl=%0d expected 0/0/0", d, gidx_v[d], terr_v[d], tcl_v[d]); end
            checks++; if (addr_v[d] !== 11'h0 || dwr_v[d] !== 32'h0 || wer_v[d] !== 1'b0) begin errors++;
                $display("FAIL reset_port dut%0d addr=%h data=%h we=%b expected 0", d, addr_v[d], dwr_v[d], wer_v[d]); end
        end
        zero_inputs();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        checks++; if (busy_v[0] !== 1'b0) begin errors++;
            $display("FAIL reset_release busy=%b expected 0", busy_v[0]); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req_v[0] = 4'b0110;
        @(negedge clk); req_v[0] = 4'b0000; #1;
        checks++; if (en_v[0] !== 4'b0010 || busy_v[0] !== 1'b1 || gidx_v[0] !== 3'd1) begin errors++;
            $display("FAIL fixed_first enable=%b busy=%b gidx=%0d expected 0010/1/1", en_v[0], busy_v[0], gidx_v[0]); end
        ack_v[0] = 4'b0010;
        @(negedge clk); ack_v[0] = 4'b0000; #1;
        checks++; if (en_v[0] !== 4'b0000 || busy_v[0] !== 1'b0) begin errors++;
            $display("FAIL fixed_gap enable=%b busy=%b expected 0000/0", en_v[0], busy_v[0]); end
        @(negedge clk); #1;
        checks++; if (en_v[0] !== 4'b0100) begin errors++;
            $display("FAIL fixed_second enable=%b expected 0100", en_v[0]); end
        ack_v[0] = 4'b0100;
        @(negedge clk); ack_v[0] = 4'b0000; #1;
        @(negedge clk); #1;
        checks++; if (en_v[0] !== 4'b0000 || busy_v[0] !== 1'b0) begin errors++;
            $display("FAIL fixed_idle enable=%b busy=%b expected 0000/0", en_v[0], busy_v[0]); end
    endtask

    task automatic test_invert_mux();
        do_reset();
        caddr_v[0] = {11'h123, 11'h456, 11'h005, 11'h005};
        cdata_v[0] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        cwe_v[0]   = 4'b0010;
        req_v[0]   = 4'b0010;
        @(negedge clk); req_v[0] = 4'b0000; ack_v[0] = 4'b0001; #1;
        checks++; if (addr_v[0] !== 11'h7FA) begin errors++;
            $display("FAIL invert_addr got %h expected 7fa", addr_v[0]); end
        checks++; if (dwr_v[0] !== 32'h11111111 || wer_v[0] !== 1'b1) begin errors++;
            $display("FAIL mux_client1 data=%h we=%b expected 11111111/1", dwr_v[0], wer_v[0]); end
        @(negedge clk); ack_v[0] = 4'b0010; #1;
        checks++; if (en_v[0] !== 4'b0010) begin errors++;
            $display("FAIL foreign_ack enable=%b expected 0010", en_v[0]); end
        @(negedge clk); ack_v[0] = 4'b0000; req_v[0] = 4'b0001;
        @(negedge clk); req_v[0] = 4'b0000; #1;
        checks++; if (en_v[0] !== 4'b0001 || addr_v[0] !== 11'h005) begin errors++;
            $display("FAIL plain_addr enable=%b addr=%h expected 0001/005", en_v[0], addr_v[0]); end
        checks++; if (dwr_v[0] !== 32'h00000000 || wer_v[0] !== 1'b0) begin errors++;
            $display("FAIL mux_client0 data=%h we=%b expected 0/0", dwr_v[0], wer_v[0]); end
        ack_v[0] = 4'b0001;
        @(negedge clk); ack_v[0] = 4'b0000; #1;
        checks++; if (addr_v[0] !== 11'h000 || wer_v[0] !== 1'b0) begin errors++;
            $display("FAIL idle_port addr=%h we=%b expected 000/0", addr_v[0], wer_v[0]); end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        req_v[0] = 4'b0100;
        @(negedge clk); req_v[0] = 4'b0000;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (en_v[0] !== 4'b0100) break;
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt != 8) begin errors++;
            $display("FAIL timeout_len grant cycles=%0d expected 8", cnt); end
        checks++; if (terr_v[0] !== 1'b1 || tcl_v[0] !== 3'd2 || en_v[0] !== 4'b0000) begin errors++;
            $display("FAIL timeout_flag terr=%b tcl=%0d enable=%b expected 1/2/0000", terr_v[0], tcl_v[0], en_v[0]); end
        @(negedge clk); clr_v[0] = 1'b1;
        @(negedge clk); clr_v[0] = 1'b0; #1;
        checks++; if (terr_v[0] !== 1'b0 || tcl_v[0] !== 3'd0) begin errors++;
            $display("FAIL timeout_clear terr=%b tcl=%0d expected 0/0", terr_v[0], tcl_v[0]); end
        req_v[0] = 4'b0100;
        @(negedge clk); req_v[0] = 4'b0000;
        repeat (7) @(negedge clk);
        #1;
        checks++; if (en_v[0] !== 4'b0100) begin errors++;
            $display("FAIL timeout_lastcycle enable=%b expected 0100", en_v[0]); end
        ack_v[0] = 4'b0100;
        @(negedge clk); ack_v[0] = 4'b0000; #1;
        checks++; if (terr_v[0] !== 1'b0 || en_v[0] !== 4'b0000) begin errors++;
            $display("FAIL timeout_ackwins terr=%b enable=%b expected 0/0000", terr_v[0], en_v[0]); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_v[1] = 4'b1111;
        @(negedge clk); req_v[1] = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (gidx_v[1] !== 3'(k) || en_v[1] !== (4'b0001 << k)) begin errors++;
                $display("FAIL rr_order step%0d gidx=%0d enable=%b expected %0d", k, gidx_v[1], en_v[1], k); end
            ack_v[1] = 4'b0001 << k;
            @(negedge clk); ack_v[1] = 4'b0000;
            @(negedge clk);
        end
        req_v[1] = 4'b0001;
        @(negedge clk); req_v[1] = 4'b0000; #1;
        checks++; if (en_v[1] !== 4'b0001) begin errors++;
            $display("FAIL rr_wrap enable=%b expected 0001", en_v[1]); end
        ack_v[1] = 4'b0001;
        @(negedge clk); ack_v[1] = 4'b0000; req_v[1] = 4'b1001;
        @(negedge clk); req_v[1] = 4'b0000; #1;
        checks++; if (en_v[1] !== 4'b1000) begin errors++;
            $display("FAIL rr_rotate enable=%b expected 1000", en_v[1]); end
    endtask

    task automatic test_follow();
        do_reset();
        caddr_v[2] = {11'h0F0, 11'h000, 11'h000, 11'h000};
        req_v[2] = 4'b0010;
        @(negedge clk); req_v[2] = 4'b1000; #1;
        checks++; if (en_v[2] !== 4'b0010) begin errors++;
            $display("FAIL follow_first enable=%b expected 0010", en_v[2]); end
        @(negedge clk); req_v[2] = 4'b0000; ack_v[2] = 4'b0010;
        @(negedge clk); ack_v[2] = 4'b0000; #1;
        checks++; if (en_v[2] !== 4'b1000 || busy_v[2] !== 1'b1 || gidx_v[2] !== 3'd3) begin errors++;
            $display("FAIL follow_chain enable=%b busy=%b gidx=%0d expected 1000/1/3", en_v[2], busy_v[2], gidx_v[2]); end
        checks++; if (addr_v[2] !== 11'h70F) begin errors++;
            $display("FAIL follow_addr got %h expected 70f", addr_v[2]); end
        ack_v[2] = 4'b1000;
        @(negedge clk); ack_v[2] = 4'b0000; #1;
        @(negedge clk); #1;
        checks++; if (en_v[2] !== 4'b0000 || busy_v[2] !== 1'b0) begin errors++;
            $display("FAIL follow_consumed enable=%b busy=%b expected 0000/0", en_v[2], busy_v[2]); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        cwe_v[0] = 4'b0001;
        caddr_v[0] = {11'h0, 11'h0, 11'h0, 11'h3C3};
        req_v[0] = 4'b0101;
        @(negedge clk); req_v[0] = 4'b0000; #1;
        checks++; if (wer_v[0] !== 1'b1 || en_v[0] !== 4'b0001) begin errors++;
            $display("FAIL midreset_pre we=%b enable=%b expected 1/0001", wer_v[0], en_v[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (wer_v[0] !== 1'b0 || en_v[0] !== 4'b0000 || busy_v[0] !== 1'b0) begin errors++;
            $display("FAIL midreset_drop we=%b enable=%b busy=%b expected 0/0000/0", wer_v[0], en_v[0], busy_v[0]); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++; if (busy_v[0] !== 1'b0 || en_v[0] !== 4'b0000) begin errors++;
            $display("FAIL midreset_pending busy=%b enable=%b expected 0/0000", busy_v[0], en_v[0]); end
    endtask

    task automatic test_random(input int ncyc);
        logic [3:0]  e_en;
        logic [10:0] e_addr;
        logic [31:0] e_dat;
        logic        e_we;
        do_reset();
        model_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                req_v[d]   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                ack_v[d]   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                cwe_v[d]   = 4'($urandom);
                caddr_v[d] = 44'({$urandom, $urandom});
                cdata_v[d] = {$urandom, $urandom, $urandom, $urandom};
                clr_v[d]   = ($urandom_range(0, 15) == 0);
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                e_en   = m_busy[d] ? (4'b0001 << m_g[d]) : 4'b0000;
                e_addr = m_busy[d] ? (caddr_v[d][m_g[d]*11 +: 11] ^ (inv_of(d, m_g[d]) ? 11'h7FF : 11'h000)) : 11'h000;
                e_dat  = m_busy[d] ? cdata_v[d][m_g[d]*32 +: 32] : 32'h0;
                e_we   = m_busy[d] ? cwe_v[d][m_g[d]] : 1'b0;
                checks++; if (en_v[d] !== e_en || busy_v[d] !== m_busy[d]) begin errors++;
                    $display("FAIL rand_grant dut%0d cyc%0d enable=%b busy=%b expected %b/%b", d, c, en_v[d], busy_v[d], e_en, m_busy[d]); end
                checks++; if (gidx_v[d] !== 3'(m_g[d])) begin errors++;
                    $display("FAIL rand_gidx dut%0d cyc%0d got %0d expected %0d", d, c, gidx_v[d], m_g[d]); end
                checks++; if (addr_v[d] !== e_addr || dwr_v[d] !== e_dat || wer_v[d] !== e_we) begin errors++;
                    $display("FAIL rand_port dut%0d cyc%0d addr=%h data=%h we=%b expected %h/%h/%b", d, c, addr_v[d], dwr_v[d], wer_v[d], e_addr, e_dat, e_we); end
                checks++; if (terr_v[d] !== m_err[d] || tcl_v[d] !== 3'(m_errc[d])) begin errors++;
                    $display("FAIL rand_err dut%0d cyc%0d terr=%b tcl=%0d expected %b/%0d", d, c, terr_v[d], tcl_v[d], m_err[d], m_errc[d]); end
            end
            for (int d = 0; d < 3; d++) model_step(d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        zero_inputs();
        rst = 1'b1;
        test_reset();
        test_fixed_priority();
        test_invert_mux();
        test_timeout();
        test_round_robin();
        test_follow();
        test_reset_mid_grant();
        test_random(1500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
